wb_arbiter: RTL and testbench

- Write-side driver of the processor's register file: merges two result producers into the single register-file write port.
  - Single-cycle ALU path.
  - Variable-latency load/multiply path (LSU) with valid/ready handshake.
- Buffers LSU results in a small in-order FIFO and enforces newest-write-wins ordering.
- Provides a forwarding lookup so decode can see writes not yet committed.
- Sits between execute/memory units and the register file write port (en/addr/data).

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the buffered-result entry type for the register-file
// write-back arbiter.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order LSU result buffer: kill-by-address of older entries and a
// youngest-first address lookup used for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [ADDR_W-1:0] i_kill_addr,
  input  logic [ADDR_W-1:0] i_qry_addr,
  output logic              o_qry_hit,
  output logic [DATA_W-1:0] o_qry_data,
  output wb_entry_t         o_head,
  output logic [CNT_W-1:0]  o_count
);

  wb_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_idx;

  // NOTE: entries are reset because their valid bits drive forwarding and
  // the output stage; nothing stale may survive a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking updates; the later push write deliberately
      // overrides a kill on the same slot, so the newer entry survives.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (i_kill && r_mem[i].addr == i_kill_addr) r_mem[i].valid <= 1'b0;
      end
      if (i_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_mem[r_wr_ptr].valid <= 1'b1;
        r_mem[r_wr_ptr].addr  <= i_push_addr;
        r_mem[r_wr_ptr].data  <= i_push_data;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins; popped slots are
  // invalidated, so valid already implies occupied.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    o_qry_hit  = 1'b0;
    o_qry_data = '0;
    w_idx      = r_rd_ptr;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_mem[w_idx].valid && r_mem[w_idx].addr == i_qry_addr) begin
        o_qry_hit  = 1'b1;
        o_qry_data = r_mem[w_idx].data;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: single-cycle ALU results versus buffered
// LSU results, with anti-starvation stall and a forwarding lookup.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDR_W-1:0]           alu_addr,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [ADDR_W-1:0]           lsu_addr,
  input  logic [DATA_W-1:0]           lsu_data,
  output logic                        rg_wrt_en,
  output logic [ADDR_W-1:0]           rg_wrt_addr,
  output logic [DATA_W-1:0]           rg_wrt_data,
  output logic                        stall_alu,
  input  logic [ADDR_W-1:0]           fwd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic              r_wrt_en;
  logic [ADDR_W-1:0] r_wrt_addr;
  logic [DATA_W-1:0] r_wrt_data;
  logic              r_stall;
  logic [STV_W-1:0]  r_starve;

  logic [CNT_W-1:0]  w_count;
  wb_entry_t         w_head;
  logic              w_nonempty;
  logic              w_alu_win;
  logic              w_pop;
  logic              w_push;
  logic              w_qry_hit;
  logic [DATA_W-1:0] w_qry_data;
  logic [STV_W-1:0]  w_starve_nxt;

  assign w_nonempty = (w_count != '0);
  assign lsu_ready  = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push     = lsu_valid && lsu_ready && (lsu_addr != '0);
  // An ALU result offered during a stall is a protocol violation and dropped.
  assign w_alu_win  = alu_valid && !r_stall && (alu_addr != '0);
  assign w_pop      = w_nonempty && !w_alu_win;

  // When the FIFO is non-empty and nothing pops, the ALU must have won.
  assign w_starve_nxt = (w_pop || !w_nonempty) ? '0 : r_starve + STV_W'(1);

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (lsu_addr),
    .i_push_data (lsu_data),
    .i_pop       (w_pop),
    .i_kill      (w_alu_win),
    .i_kill_addr (alu_addr),
    .i_qry_addr  (fwd_addr),
    .o_qry_hit   (w_qry_hit),
    .o_qry_data  (w_qry_data),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrt_en   <= 1'b0;
      r_wrt_addr <= '0;
      r_wrt_data <= '0;
      r_stall    <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == STV_W'(STARVE_MAX));
      if (w_alu_win) begin
        r_wrt_en   <= 1'b1;
        r_wrt_addr <= alu_addr;
        r_wrt_data <= alu_data;
      end else if (w_pop) begin
        // A killed head still pops, but produces no write.
        r_wrt_en <= w_head.valid;
        if (w_head.valid) begin
          r_wrt_addr <= w_head.addr;
          r_wrt_data <= w_head.data;
        end
      end else begin
        r_wrt_en <= 1'b0;
      end
    end
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (r_wrt_en && r_wrt_addr == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = r_wrt_data;
      end else if (w_qry_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = w_qry_data;
      end
    end
  end

  assign rg_wrt_en   = r_wrt_en;
  assign rg_wrt_addr = r_wrt_addr;
  assign rg_wrt_data = r_wrt_data;
  assign stall_alu   = r_stall;
  assign fifo_count  = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, fill/starvation, kill,
// forwarding, pointer wrap and mid-stream reset.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              lsu_valid = 1'b0;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr = '0;
  logic [DATA_W-1:0] lsu_data = '0;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic              stall_alu;
  logic [ADDR_W-1:0] fwd_addr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [2:0]        fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_addr    (lsu_addr),
    .lsu_data    (lsu_data),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .stall_alu   (stall_alu),
    .fwd_addr    (fwd_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // The upstream must never offer an ALU result while stalled.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(stall_alu && alu_valid)) else begin
        n_err++;
        $error("FAIL proto: alu_valid=1 while stall_alu=1");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_addr  = '0;
    lsu_data  = '0;
  endtask

  task automatic drv_alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic drv_lsu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    lsu_valid = 1'b1;
    lsu_addr  = a;
    lsu_data  = d;
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    check({tag, ".en"}, 32'(rg_wrt_en), 32'(en));
    check({tag, ".addr"}, 32'(rg_wrt_addr), 32'(a));
    check({tag, ".data"}, rg_wrt_data, d);
  endtask

  initial begin
    // ---- reset state ----
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.ready", 32'(lsu_ready), 32'd1);
    check("rst.stall", 32'(stall_alu), 32'd0);
    reset = 1'b1;
    tick();

    // ---- ALU only ----
    drv_alu(5'd5, 32'h0000_00AA);
    tick();
    expect_wr("alu5", 1'b1, 5'd5, 32'hAA);
    fwd_addr = 5'd5;
    #1;
    check("alu5.fwd_hit", 32'(fwd_hit), 32'd1);
    check("alu5.fwd_data", fwd_data, 32'hAA);
    fwd_addr = '0;
    drv_alu(5'd0, 32'h55);
    tick();
    expect_wr("alu0", 1'b0, 5'd5, 32'hAA);

    // ---- priority, fill and starvation ----
    for (int i = 0; i < 9; i++) begin
      drv_alu(5'(10 + i), 32'(32'h100 + i));
      if (i < 4) drv_lsu(5'(1 + i), 32'(32'hA1 + i));
      else       drv_lsu(5'd6, 32'hEE);
      tick();
      expect_wr($sformatf("fill%0d", i), 1'b1, 5'(10 + i), 32'(32'h100 + i));
      if (i == 3) begin
        check("fill.count4", 32'(fifo_count), 32'd4);
        check("fill.ready0", 32'(lsu_ready), 32'd0);
      end
      if (i == 7) check("starve.stall7", 32'(stall_alu), 32'd0);
    end
    check("starve.stall8", 32'(stall_alu), 32'd1);
    check("starve.count", 32'(fifo_count), 32'd4);
    idle();
    tick();
    expect_wr("forced_pop", 1'b1, 5'd1, 32'hA1);
    check("forced.stall", 32'(stall_alu), 32'd0);
    check("forced.count", 32'(fifo_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_wr($sformatf("drain%0d", i), 1'b1, 5'(1 + i), 32'(32'hA1 + i));
    end
    tick();
    check("drain.en0", 32'(rg_wrt_en), 32'd0);
    check("drain.count0", 32'(fifo_count), 32'd0);

    // ---- kill ----
    drv_lsu(5'd7, 32'h11);
    tick();
    check("kill.push_en", 32'(rg_wrt_en), 32'd0);
    check("kill.count1", 32'(fifo_count), 32'd1);
    idle();
    drv_alu(5'd7, 32'h22);
    tick();
    expect_wr("kill.alu", 1'b1, 5'd7, 32'h22);
    fwd_addr = 5'd7;
    #1;
    check("kill.fwd_data", fwd_data, 32'h22);
    fwd_addr = '0;
    idle();
    tick();
    expect_wr("kill.pop_dead", 1'b0, 5'd7, 32'h22);
    check("kill.count0", 32'(fifo_count), 32'd0);
    drv_alu(5'd8, 32'h33);
    drv_lsu(5'd8, 32'h44);
    tick();
    expect_wr("same_edge.alu", 1'b1, 5'd8, 32'h33);
    check("same_edge.count", 32'(fifo_count), 32'd1);
    idle();
    tick();
    expect_wr("same_edge.pop", 1'b1, 5'd8, 32'h44);

    // ---- forwarding ----
    drv_alu(5'd12, 32'h312);
    drv_lsu(5'd9, 32'h1);
    tick();
    drv_alu(5'd13, 32'h313);
    drv_lsu(5'd9, 32'h2);
    tick();
    idle();
    check("fwd.count2", 32'(fifo_count), 32'd2);
    fwd_addr = 5'd9;
    #1;
    check("fwd9.hit", 32'(fwd_hit), 32'd1);
    check("fwd9.data", fwd_data, 32'h2);
    fwd_addr = 5'd0;
    #1;
    check("fwd0.hit", 32'(fwd_hit), 32'd0);
    check("fwd0.data", fwd_data, 32'h0);
    fwd_addr = 5'd13;
    #1;
    check("fwd13.hit", 32'(fwd_hit), 32'd1);
    check("fwd13.data", fwd_data, 32'h313);
    fwd_addr = 5'd3;
    #1;
    check("fwd3.hit", 32'(fwd_hit), 32'd0);
    fwd_addr = '0;
    tick();
    expect_wr("fwd.pop1", 1'b1, 5'd9, 32'h1);
    tick();
    expect_wr("fwd.pop2", 1'b1, 5'd9, 32'h2);
    check("fwd.count0", 32'(fifo_count), 32'd0);
    fwd_addr = 5'd9;
    #1;
    check("fwd9.out_data", fwd_data, 32'h2);
    fwd_addr = '0;

    // ---- wrap-around with simultaneous push/pop ----
    drv_alu(5'd30, 32'h30);
    drv_lsu(5'd1, 32'h1000);
    tick();
    drv_alu(5'd31, 32'h31);
    drv_lsu(5'd2, 32'h1001);
    tick();
    check("wrap.count2", 32'(fifo_count), 32'd2);
    idle();
    for (int j = 0; j < 10; j++) begin
      drv_lsu(5'(j + 3), 32'(32'h1000 + j + 2));
      tick();
      expect_wr($sformatf("wrap%0d", j), 1'b1, 5'(j + 1), 32'(32'h1000 + j));
      check($sformatf("wrap%0d.count", j), 32'(fifo_count), 32'd2);
    end
    idle();
    tick();
    expect_wr("wrap.tail10", 1'b1, 5'd11, 32'h100A);
    tick();
    expect_wr("wrap.tail11", 1'b1, 5'd12, 32'h100B);
    check("wrap.count0", 32'(fifo_count), 32'd0);

    // ---- mid-stream asynchronous reset with 3 entries pending ----
    for (int i = 0; i < 3; i++) begin
      drv_alu(5'(25 + i), 32'(32'h250 + i));
      drv_lsu(5'(1 + i), 32'(32'hB1 + i));
      tick();
    end
    check("mrst.count3", 32'(fifo_count), 32'd3);
    check("mrst.pre_en", 32'(rg_wrt_en), 32'd1);
    idle();
    reset = 1'b0;
    #1;
    expect_wr("mrst", 1'b0, 5'd0, 32'h0);
    check("mrst.count", 32'(fifo_count), 32'd0);
    check("mrst.ready", 32'(lsu_ready), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d.en", i), 32'(rg_wrt_en), 32'd0);
      check($sformatf("post_rst%0d.count", i), 32'(fifo_count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
